// File: rtl/led_status_scheduler.sv
// Shares one RGB LED between N_REQ status requesters using fixed priority (index 0 highest).
// The winner's solid, blink or burst pattern runs on a prescaled tick, and a global brightness PWM gates the output.
//  state     | meaning
//  IDLE      | no grant; arbitrate and latch the winner
//  SOLID     | LED lit; yields on drop or on a higher-priority request
//  BLINK_ON  | lit phase, 250 ticks; re-arbitrates at phase end
//  BLINK_OFF | dark phase, 250 ticks; re-arbitrates at phase end
//  BURST_ON  | lit flash, 50 ticks; not preemptable
//  BURST_OFF | dark gap, 50 ticks; third gap ends with an ack
module led_status_scheduler #(
    parameter int N_REQ    = 4,
    parameter int TICK_DIV = 150000,
    parameter int PWM_W    = 8,
    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int PS_W    = $clog2(TICK_DIV)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [2*N_REQ-1:0]   req_mode,
    input  logic [3*N_REQ-1:0]   req_rgb,
    input  logic [PWM_W-1:0]     brightness,
    output logic [N_REQ-1:0]     req_ack,
    output logic [2:0]           rgb_pwm,
    output logic [ID_W-1:0]      active_id,
    output logic                 busy
);

    localparam int BLINK_LEN = 250;
    localparam int BURST_LEN = 50;
    localparam int BURST_CNT = 3;

    typedef enum logic [2:0] {
        IDLE,
        SOLID,
        BLINK_ON,
        BLINK_OFF,
        BURST_ON,
        BURST_OFF
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   id_q;
    logic [2:0]        rgb_q;
    logic [PS_W-1:0]   presc;
    logic [7:0]        phase;
    logic [1:0]        flash;
    logic [N_REQ-1:0]  mask;
    logic [PWM_W-1:0]  pwm_cnt;

    logic [N_REQ-1:0]  mode_nz;
    logic [N_REQ-1:0]  elig;
    logic              any_elig;
    logic [ID_W-1:0]   win;
    logic [1:0]        win_mode;
    logic [2:0]        win_rgb;
    logic [2:0]        id_rgb;
    logic [N_REQ-1:0]  id_onehot;
    logic              keep_grant;
    logic              tick;
    logic              led_on;
    logic              blink_end;
    logic              burst_end;

    always_comb begin
        mode_nz = '0;
        for (int i = 0; i < N_REQ; i++) begin
            mode_nz[i] = |req_mode[2*i +: 2];
        end
        elig     = req_valid & mode_nz & ~mask;
        any_elig = |elig;
        win      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win = ID_W'(i);
            end
        end
        win_mode   = req_mode[2*win +: 2];
        win_rgb    = req_rgb[3*win +: 3];
        id_rgb     = req_rgb[3*id_q +: 3];
        id_onehot  = N_REQ'(1) << id_q;
        // lowest eligible index is the winner, so this covers both drop and preempt
        keep_grant = any_elig && (win == id_q);
        tick       = (presc == PS_W'(TICK_DIV - 1));
        blink_end  = tick && (phase == 8'(BLINK_LEN - 1));
        burst_end  = tick && (phase == 8'(BURST_LEN - 1));
        led_on     = (state == SOLID) || (state == BLINK_ON) || (state == BURST_ON);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            id_q      <= '0;
            rgb_q     <= '0;
            presc     <= '0;
            phase     <= '0;
            flash     <= '0;
            mask      <= '0;
            pwm_cnt   <= '0;
            req_ack   <= '0;
            rgb_pwm   <= '0;
            active_id <= '0;
            busy      <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            rgb_pwm <= {3{led_on}} & rgb_q & {3{pwm_cnt < brightness}};
            req_ack <= '0;
            mask    <= mask & req_valid;
            presc   <= tick ? '0 : presc + 1'b1;

            case (state)
                IDLE: begin
                    active_id <= '0;
                    busy      <= 1'b0;
                    if (any_elig) begin
                        id_q      <= win;
                        active_id <= win;
                        busy      <= 1'b1;
                        rgb_q     <= win_rgb;
                        presc     <= '0;
                        phase     <= '0;
                        flash     <= '0;
                        case (win_mode)
                            2'b01:   state <= SOLID;
                            2'b10:   state <= BLINK_ON;
                            default: state <= BURST_ON;
                        endcase
                    end
                end

                SOLID: begin
                    rgb_q <= id_rgb;
                    if (!keep_grant) begin
                        state     <= IDLE;
                        active_id <= '0;
                        busy      <= 1'b0;
                    end
                end

                BLINK_ON, BLINK_OFF: begin
                    if (!elig[id_q]) begin
                        state     <= IDLE;
                        active_id <= '0;
                        busy      <= 1'b0;
                    end else if (blink_end) begin
                        phase <= '0;
                        if (keep_grant) begin
                            state <= (state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                        end else begin
                            state     <= IDLE;
                            active_id <= '0;
                            busy      <= 1'b0;
                        end
                    end else if (tick) begin
                        phase <= phase + 1'b1;
                    end
                end

                BURST_ON: begin
                    if (burst_end) begin
                        phase <= '0;
                        state <= BURST_OFF;
                    end else if (tick) begin
                        phase <= phase + 1'b1;
                    end
                end

                BURST_OFF: begin
                    if (burst_end) begin
                        phase <= '0;
                        if (flash == 2'(BURST_CNT - 1)) begin
                            // a requester that already dropped must not stay masked
                            mask      <= (mask | id_onehot) & req_valid;
                            req_ack   <= id_onehot;
                            state     <= IDLE;
                            active_id <= '0;
                            busy      <= 1'b0;
                        end else begin
                            flash <= flash + 1'b1;
                            state <= BURST_ON;
                        end
                    end else if (tick) begin
                        phase <= phase + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    active_id <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_status_scheduler.sv
// Directed bench for led_status_scheduler with TICK_DIV=4, so a blink phase is 1000 cycles and a burst phase is 200 cycles.
module tb_led_status_scheduler;

    localparam int N_REQ    = 4;
    localparam int TICK_DIV = 4;
    localparam int PWM_W    = 8;

    logic               sys_clk = 1'b0;
    logic               sys_rst = 1'b1;
    logic [N_REQ-1:0]   req_valid;
    logic [2*N_REQ-1:0] req_mode;
    logic [3*N_REQ-1:0] req_rgb;
    logic [PWM_W-1:0]   brightness;
    logic [N_REQ-1:0]   req_ack;
    logic [2:0]         rgb_pwm;
    logic [1:0]         active_id;
    logic               busy;

    int n_checks = 0;
    int n_errors = 0;

    led_status_scheduler #(
        .N_REQ    (N_REQ),
        .TICK_DIV (TICK_DIV),
        .PWM_W    (PWM_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .req_valid  (req_valid),
        .req_mode   (req_mode),
        .req_rgb    (req_rgb),
        .brightness (brightness),
        .req_ack    (req_ack),
        .rgb_pwm    (rgb_pwm),
        .active_id  (active_id),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] mode, input logic [2:0] rgb, input logic v);
        req_mode[2*i +: 2] = mode;
        req_rgb[3*i +: 3]  = rgb;
        req_valid[i]       = v;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_mode  = '0;
        req_rgb   = '0;
        step();
        step();
    endtask

    // counts cycles showing pat, and cycles showing anything other than pat or dark
    task automatic count_win(input int n, input logic [2:0] pat, output int lit, output int bad);
        lit = 0;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (rgb_pwm == pat) lit++;
            else if (rgb_pwm != 3'b000) bad++;
        end
    endtask

    initial begin
        int lit, bad, lit2, bad2;
        int on_lit, gap_lit, burst_bad, ack_n, ack_j, other_ack, id_bad;
        logic idle_busy;
        logic [2:0] g0;

        // reset held with every requester asking for solid
        req_valid  = 4'b1111;
        req_mode   = 8'b01_01_01_01;
        req_rgb    = 12'hFFF;
        brightness = 8'd255;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_outputs", {rgb_pwm, req_ack, active_id, busy}, 32'h0);
        end
        sys_rst = 1'b0;
        step();
        check("rst_release_id_busy", {active_id, busy}, 3'b001);
        clear_all();
        check("idle_after_clear", busy, 1'b0);

        // solid at half brightness
        brightness = 8'd128;
        set_req(1, 2'b01, 3'b010, 1'b1);
        step();
        check("solid_grant", {active_id, busy}, 3'b011);
        step();
        count_win(256, 3'b010, lit, bad);
        check("solid_half_lit", lit, 128);
        check("solid_half_bad", bad, 0);
        req_valid[1] = 1'b0;
        step();
        step();
        check("solid_drop_dark", rgb_pwm, 3'b000);
        check("solid_drop_idle", busy, 1'b0);
        clear_all();

        // priority, then blink after the higher requester drops
        brightness = 8'd255;
        set_req(0, 2'b01, 3'b001, 1'b1);
        set_req(2, 2'b10, 3'b100, 1'b1);
        step();
        check("prio_grant0", {active_id, busy}, 3'b001);
        req_valid[0] = 1'b0;
        step();
        check("prio_idle_gap", busy, 1'b0);
        step();
        check("prio_grant2", {active_id, busy}, 3'b101);
        count_win(1000, 3'b100, lit, bad);
        check("blink_on_lit", (lit >= 996 && lit <= 997), 1'b1);
        count_win(1000, 3'b100, lit2, bad2);
        check("blink_off_lit", lit2, 0);
        check("blink_bad", bad + bad2, 0);
        count_win(200, 3'b100, lit, bad);
        check("blink_reon_lit", (lit >= 199), 1'b1);
        check("blink_still_2", {active_id, busy}, 3'b101);
        clear_all();
        check("blink_drop_idle", busy, 1'b0);

        // blink preempted only at its phase end
        set_req(1, 2'b10, 3'b010, 1'b1);
        step();
        check("bpre_grant1", {active_id, busy}, 3'b011);
        repeat (100) step();
        set_req(0, 2'b01, 3'b001, 1'b1);
        repeat (899) step();
        check("bpre_hold", {active_id, busy}, 3'b011);
        step();
        check("bpre_phase_end_idle", {active_id, busy}, 3'b000);
        step();
        check("bpre_grant0", {active_id, busy}, 3'b001);
        clear_all();

        // burst with a mid-burst higher-priority request
        set_req(3, 2'b11, 3'b111, 1'b1);
        step();
        check("burst_grant3", {active_id, busy}, 3'b111);
        on_lit = 0; gap_lit = 0; burst_bad = 0; ack_n = 0; ack_j = 0;
        other_ack = 0; id_bad = 0; idle_busy = 1'b1; g0 = '0;
        for (int j = 1; j <= 1205; j++) begin
            step();
            if ((j >= 1 && j <= 200) || (j >= 401 && j <= 600) || (j >= 801 && j <= 1000)) begin
                if (rgb_pwm != 3'b000) on_lit++;
            end else if (j <= 1200) begin
                if (rgb_pwm != 3'b000) gap_lit++;
            end
            if (j <= 1200 && rgb_pwm != 3'b000 && rgb_pwm != 3'b111) burst_bad++;
            if (req_ack[3]) begin
                ack_n++;
                ack_j = j;
            end
            if (req_ack[2:0] != 3'b000) other_ack++;
            if (j < 1200 && active_id != 2'd3) id_bad++;
            if (j == 1200) idle_busy = busy;
            if (j == 1201) g0 = {active_id, busy};
            if (j == 300) set_req(0, 2'b01, 3'b001, 1'b1);
        end
        check("burst_on_lit", (on_lit >= 597 && on_lit <= 600), 1'b1);
        check("burst_gap_lit", gap_lit, 0);
        check("burst_colour", burst_bad, 0);
        check("burst_ack_count", ack_n, 1);
        check("burst_ack_cycle", ack_j, 1200);
        check("burst_other_ack", other_ack, 0);
        check("burst_not_preempted", id_bad, 0);
        check("burst_ack_idle", idle_busy, 1'b0);
        check("burst_then_grant0", g0, 3'b001);
        req_valid[0] = 1'b0;
        repeat (4) step();
        check("burst_masked", busy, 1'b0);
        req_valid[3] = 1'b0;
        step();
        req_valid[3] = 1'b1;
        step();
        check("burst_regrant", {active_id, busy}, 3'b111);

        // reset in the middle of a burst
        repeat (50) step();
        sys_rst = 1'b1;
        step();
        check("rst_midburst", {rgb_pwm, req_ack, active_id, busy}, 32'h0);
        req_valid = '0;
        req_mode  = '0;
        step();
        check("rst_midburst_ack", req_ack, 4'b0000);
        sys_rst = 1'b0;
        step();

        // brightness extremes
        brightness = 8'd0;
        set_req(2, 2'b01, 3'b101, 1'b1);
        step();
        check("bright_grant", {active_id, busy}, 3'b101);
        step();
        count_win(256, 3'b101, lit, bad);
        check("bright0_lit", lit, 0);
        brightness = 8'd255;
        step();
        count_win(256, 3'b101, lit, bad);
        check("bright255_lit", lit, 255);
        check("bright255_bad", bad, 0);
        clear_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
